// File: rtl/dds_stream_packer.sv
// rtl/dds_stream_packer.sv - packs 16-bit DDS samples into a framed 32-bit AXI4-Stream
// Sample pairs become words; completed words enter a FWFT FIFO, or are dropped and counted when it is full.
module dds_stream_packer #(
  parameter int FIFO_DEPTH = 16,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                          AXIS_ACLK,
  input  logic                          AXIS_ARESET,
  input  logic [15:0]                   in_sample,
  input  logic                          in_valid,
  input  logic                          enable,
  input  logic [LEN_WIDTH-1:0]          frame_len,
  input  logic                          clear_ovf,
  output logic [31:0]                   M_AXIS_TDATA,
  output logic [3:0]                    M_AXIS_TKEEP,
  output logic                          M_AXIS_TLAST,
  output logic                          M_AXIS_TVALID,
  input  logic                          M_AXIS_TREADY,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          ovf,
  output logic [LEN_WIDTH-1:0]          drop_count
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LVW = AW + 1;

  logic                 en_q;
  logic [15:0]          slot0_q, slot0_d;
  logic                 has0_q, has0_d;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d, len_q, len_d, len_eff;
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [LVW-1:0]       level_q, level_d;
  logic                 ovf_q, ovf_d;
  logic [LEN_WIDTH-1:0] drop_q, drop_d;
  logic [LEN_WIDTH:0]   drop_sum;
  logic [33:0]          mem [FIFO_DEPTH];
  logic [33:0]          head;

  logic        accept, flush, is_last, pop, full, wr_en, drop;
  logic        word_vld, word_half, word_last;
  logic [31:0] word_data;

  always_comb begin
    accept  = in_valid && enable;
    flush   = en_q && !enable && has0_q;
    // A new frame's length is taken straight from the input on its first sample.
    len_eff = (cnt_q == '0) ? frame_len : len_q;
    is_last = accept && (len_eff != '0) && (cnt_q == len_eff - LEN_WIDTH'(1));

    word_vld  = 1'b0;
    word_half = 1'b0;
    word_last = 1'b0;
    word_data = 32'h0;
    if (flush) begin
      word_vld  = 1'b1;
      word_half = 1'b1;
      word_last = 1'b1;
      word_data = {16'h0, slot0_q};
    end else if (accept && has0_q) begin
      word_vld  = 1'b1;
      word_last = is_last;
      word_data = {in_sample, slot0_q};
    end else if (is_last) begin
      word_vld  = 1'b1;
      word_half = 1'b1;
      word_last = 1'b1;
      word_data = {16'h0, in_sample};
    end

    pop   = M_AXIS_TVALID && M_AXIS_TREADY;
    full  = (level_q == LVW'(FIFO_DEPTH));
    wr_en = word_vld && (!full || pop);
    drop  = word_vld && !wr_en;

    slot0_d = (accept && !has0_q) ? in_sample : slot0_q;
    has0_d  = has0_q;
    cnt_d   = cnt_q;
    len_d   = (accept && cnt_q == '0) ? frame_len : len_q;
    if (flush) begin
      has0_d = 1'b0;
      cnt_d  = '0;
    end else if (accept) begin
      has0_d = !has0_q && !is_last;
      cnt_d  = (is_last || len_eff == '0) ? '0 : cnt_q + LEN_WIDTH'(1);
    end

    level_d  = level_q + LVW'(wr_en) - LVW'(pop);
    drop_sum = {1'b0, drop_q} + (word_half ? (LEN_WIDTH+1)'(1) : (LEN_WIDTH+1)'(2));
    ovf_d    = ovf_q;
    drop_d   = drop_q;
    if (clear_ovf) begin
      ovf_d  = 1'b0;
      drop_d = '0;
    end else if (drop) begin
      ovf_d  = 1'b1;
      drop_d = drop_sum[LEN_WIDTH] ? '1 : drop_sum[LEN_WIDTH-1:0];
    end
  end

  always_ff @(posedge AXIS_ACLK) begin
    if (AXIS_ARESET) begin
      en_q     <= 1'b0;
      slot0_q  <= '0;
      has0_q   <= 1'b0;
      cnt_q    <= '0;
      len_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
    end else begin
      en_q     <= enable;
      slot0_q  <= slot0_d;
      has0_q   <= has0_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  // Storage needs no reset: the outputs are gated by the reset-cleared level.
  always_ff @(posedge AXIS_ACLK) begin
    if (wr_en) mem[wr_ptr_q] <= {word_last, word_half, word_data};
  end

  always_comb begin
    head          = mem[rd_ptr_q];
    M_AXIS_TVALID = (level_q != '0);
    M_AXIS_TDATA  = M_AXIS_TVALID ? head[31:0] : 32'h0;
    M_AXIS_TKEEP  = !M_AXIS_TVALID ? 4'b0000 : (head[32] ? 4'b0011 : 4'b1111);
    M_AXIS_TLAST  = M_AXIS_TVALID && head[33];
  end

  assign fifo_level = level_q;
  assign ovf        = ovf_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_dds_stream_packer.sv
// tb/tb_dds_stream_packer.sv - scoreboard bench for dds_stream_packer
// A sample-level reference model predicts beats and drops; a negedge monitor checks the stream.
module tb_dds_stream_packer;

  localparam int D  = 4;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          AXIS_ARESET, in_valid, enable, clear_ovf, M_AXIS_TREADY;
  logic [15:0]   in_sample;
  logic [LW-1:0] frame_len;
  logic [31:0]   M_AXIS_TDATA;
  logic [3:0]    M_AXIS_TKEEP;
  logic          M_AXIS_TLAST, M_AXIS_TVALID, ovf;
  logic [$clog2(D):0] fifo_level;
  logic [LW-1:0] drop_count;

  dds_stream_packer #(.FIFO_DEPTH(D), .LEN_WIDTH(LW)) dut (
    .AXIS_ACLK(clk), .AXIS_ARESET(AXIS_ARESET), .in_sample(in_sample), .in_valid(in_valid),
    .enable(enable), .frame_len(frame_len), .clear_ovf(clear_ovf),
    .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TKEEP(M_AXIS_TKEEP), .M_AXIS_TLAST(M_AXIS_TLAST),
    .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TREADY(M_AXIS_TREADY),
    .fifo_level(fifo_level), .ovf(ovf), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        half;
    logic        last;
  } word_t;

  word_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  logic  started  = 1'b0;

  // Reference model state: sample pairing, frame position and overflow bookkeeping.
  logic [15:0] half_s;
  logic        have_half = 1'b0, prev_en = 1'b0;
  int          pos = 0, cur_len = 0;
  logic        exp_ovf = 1'b0, nxt_ovf = 1'b0;
  int          exp_drop = 0, nxt_drop = 0;
  word_t       pend_w;
  logic        pend_vld = 1'b0, pend_rst = 1'b0;

  logic        en_g = 1'b0, rdy_g = 1'b0, clr_g = 1'b0, rst_g = 1'b0;
  logic [15:0] fl_g = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic v, input logic [15:0] s);
    word_t w;
    logic  wv, last;
    @(posedge clk);
    #1;
    if (pend_rst) begin
      exp_q.delete();
      have_half = 1'b0; prev_en = 1'b0; pos = 0; cur_len = 0;
      exp_ovf = 1'b0; exp_drop = 0; nxt_ovf = 1'b0; nxt_drop = 0;
      pend_rst = 1'b0; pend_vld = 1'b0;
    end else begin
      if (pend_vld) exp_q.push_back(pend_w);
      pend_vld = 1'b0;
      exp_ovf  = nxt_ovf;
      exp_drop = nxt_drop;
    end
    in_valid = v; in_sample = s; enable = en_g; M_AXIS_TREADY = rdy_g;
    frame_len = fl_g; clear_ovf = clr_g; AXIS_ARESET = rst_g;
    if (rst_g) begin
      pend_rst = 1'b1;
    end else begin
      wv = 1'b0;
      w  = '{32'h0, 1'b0, 1'b0};
      if (v && en_g) begin
        if (pos == 0) cur_len = int'(fl_g);
        last = (cur_len != 0) && (pos == cur_len - 1);
        pos  = (last || cur_len == 0) ? 0 : pos + 1;
        if (have_half) begin
          w = '{{s, half_s}, 1'b0, last}; wv = 1'b1; have_half = 1'b0;
        end else if (last) begin
          w = '{{16'h0, s}, 1'b1, 1'b1}; wv = 1'b1;
        end else begin
          half_s = s; have_half = 1'b1;
        end
      end else if (prev_en && !en_g && have_half) begin
        w = '{{16'h0, half_s}, 1'b1, 1'b1}; wv = 1'b1; have_half = 1'b0; pos = 0;
      end
      prev_en  = en_g;
      nxt_ovf  = exp_ovf;
      nxt_drop = exp_drop;
      if (wv) begin
        if (exp_q.size() < D || (exp_q.size() > 0 && rdy_g)) begin
          pend_w = w; pend_vld = 1'b1;
        end else begin
          nxt_ovf  = 1'b1;
          nxt_drop = (exp_drop + (w.half ? 1 : 2) > 65535) ? 65535 : exp_drop + (w.half ? 1 : 2);
        end
      end
      if (clr_g) begin
        nxt_ovf = 1'b0; nxt_drop = 0;
      end
    end
    clr_g = 1'b0;
    rst_g = 1'b0;
  endtask

  always @(negedge clk) begin
    if (started && !AXIS_ARESET) begin
      chk("fifo_level", 32'(fifo_level), 32'(exp_q.size()));
      chk("tvalid", 32'(M_AXIS_TVALID), 32'(exp_q.size() != 0));
      chk("ovf", 32'(ovf), 32'(exp_ovf));
      chk("drop_count", 32'(drop_count), 32'(exp_drop));
      if (M_AXIS_TVALID && exp_q.size() != 0) begin
        chk("tdata_lo", 32'(M_AXIS_TDATA[15:0]), 32'(exp_q[0].data[15:0]));
        if (!exp_q[0].half) chk("tdata_hi", 32'(M_AXIS_TDATA[31:16]), 32'(exp_q[0].data[31:16]));
        chk("tkeep", 32'(M_AXIS_TKEEP), exp_q[0].half ? 32'h3 : 32'hF);
        chk("tlast", 32'(M_AXIS_TLAST), 32'(exp_q[0].last));
        if (M_AXIS_TREADY) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    rst_g = 1'b1; step(1'b0, 16'h0);
    rst_g = 1'b1; step(1'b0, 16'h0);
    step(1'b0, 16'h0);
    started = 1'b1;
    @(negedge clk);
    chk("rst_tdata", M_AXIS_TDATA, 32'h0);
    chk("rst_tkeep", 32'(M_AXIS_TKEEP), 32'h0);
    chk("rst_tlast", 32'(M_AXIS_TLAST), 32'h0);

    // Unframed, one sample every 4th cycle.
    en_g = 1'b1; rdy_g = 1'b1; fl_g = 16'd0;
    step(1'b1, 16'd1); repeat (3) step(1'b0, 16'h0);
    step(1'b1, 16'd2); step(1'b0, 16'h0);
    @(negedge clk);
    chk("unframed_valid0", 32'(M_AXIS_TVALID), 32'h1);
    chk("unframed_beat0", M_AXIS_TDATA, 32'h00020001);
    repeat (2) step(1'b0, 16'h0);
    step(1'b1, 16'd3); repeat (3) step(1'b0, 16'h0);
    step(1'b1, 16'd4); step(1'b0, 16'h0);
    @(negedge clk);
    chk("unframed_beat1", M_AXIS_TDATA, 32'h00040003);
    repeat (3) step(1'b0, 16'h0);

    // Odd frame length.
    fl_g = 16'd3;
    for (int i = 0; i < 6; i++) step(1'b1, 16'(16 + i));
    repeat (4) step(1'b0, 16'h0);

    // Backpressure and overflow.
    rdy_g = 1'b0; fl_g = 16'd0;
    for (int i = 0; i < 12; i++) step(1'b1, 16'(100 + i));
    step(1'b0, 16'h0);
    @(negedge clk);
    chk("bp_level", 32'(fifo_level), 32'd4);
    chk("bp_ovf", 32'(ovf), 32'd1);
    chk("bp_drop", 32'(drop_count), 32'd4);
    repeat (3) step(1'b0, 16'h0);
    rdy_g = 1'b1;
    repeat (6) step(1'b0, 16'h0);
    @(negedge clk);
    chk("bp_drained", 32'(M_AXIS_TVALID), 32'd0);
    clr_g = 1'b1; step(1'b0, 16'h0);
    step(1'b0, 16'h0);
    @(negedge clk);
    chk("clr_ovf", 32'(ovf), 32'd0);
    chk("clr_drop", 32'(drop_count), 32'd0);

    // Flush on disable, then a fresh 3-sample frame.
    fl_g = 16'd3;
    step(1'b1, 16'hABCD);
    en_g = 1'b0; step(1'b0, 16'h0);
    step(1'b0, 16'h0);
    @(negedge clk);
    chk("flush_data", 32'(M_AXIS_TDATA[15:0]), 32'hABCD);
    chk("flush_keep", 32'(M_AXIS_TKEEP), 32'h3);
    chk("flush_last", 32'(M_AXIS_TLAST), 32'h1);
    en_g = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, 16'(16'h200 + i));
    repeat (3) step(1'b0, 16'h0);

    // Reset mid-operation.
    rdy_g = 1'b0; fl_g = 16'd0;
    for (int i = 0; i < 7; i++) step(1'b1, 16'(16'h300 + i));
    rst_g = 1'b1; step(1'b0, 16'h0);
    step(1'b0, 16'h0);
    @(negedge clk);
    chk("midrst_valid", 32'(M_AXIS_TVALID), 32'h0);
    chk("midrst_level", 32'(fifo_level), 32'h0);
    chk("midrst_tdata", M_AXIS_TDATA, 32'h0);
    rdy_g = 1'b1;
    step(1'b1, 16'h0401); step(1'b1, 16'h0402);
    repeat (3) step(1'b0, 16'h0);

    // Full FIFO with simultaneous write and pop.
    rdy_g = 1'b0;
    for (int i = 0; i < 9; i++) step(1'b1, 16'(16'h500 + i));
    rdy_g = 1'b1; step(1'b1, 16'h0509);
    rdy_g = 1'b0; step(1'b0, 16'h0);
    @(negedge clk);
    chk("full_wp_ovf", 32'(ovf), 32'h0);
    chk("full_wp_level", 32'(fifo_level), 32'd4);
    rdy_g = 1'b1;
    repeat (6) step(1'b0, 16'h0);

    // Randomized traffic with varying framing, stalls, clears and rare resets.
    for (int c = 0; c < 4000; c++) begin
      if (c % 150 == 0) begin
        case ($urandom_range(0, 5))
          0: fl_g = 16'd0;
          1: fl_g = 16'd1;
          2: fl_g = 16'd2;
          3: fl_g = 16'd3;
          4: fl_g = 16'd5;
          default: fl_g = 16'd8;
        endcase
      end
      en_g  = ($urandom_range(0, 24) != 0);
      rdy_g = ((c / 300) % 2 == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      clr_g = ($urandom_range(0, 120) == 0);
      rst_g = ($urandom_range(0, 700) == 0);
      step(1'($urandom_range(0, 1)), 16'($urandom));
    end
    en_g = 1'b1; rdy_g = 1'b1; fl_g = 16'd0;
    repeat (10) step(1'b0, 16'h0);
    @(negedge clk);
    chk("final_empty", 32'(M_AXIS_TVALID), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
